// File: rtl/eng_pipe_ad.sv
// Admission/decode stage ahead of eng_pipe_ca in the queue engine.
// Commands land in a one-entry holding register, are decoded and checked
// against an in-flight scoreboard, allocated a tag slot and issued through
// a registered output. Downstream retire frees slots. Illegal commands and
// retires of free slots raise a one-cycle error pulse.
module eng_pipe_ad #(
  parameter int CTX_W  = 4,
  parameter int DATA_W = 32,
  parameter int SLOT_N = 4,
  parameter int SLOT_W = $clog2(SLOT_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [2:0]        in_opcode,
  input  logic [CTX_W-1:0]  in_ctxid,
  input  logic [DATA_W-1:0] in_dat,
  output logic              in_rdy,
  output logic              out_vld,
  output logic [2:0]        out_opcode,
  output logic [CTX_W-1:0]  out_ctxid,
  output logic [DATA_W-1:0] out_dat,
  output logic [SLOT_W-1:0] out_slot,
  input  logic              out_rdy,
  input  logic              retire_vld,
  input  logic [SLOT_W-1:0] retire_slot,
  output logic              err_vld,
  output logic [1:0]        err_code,
  output logic [CTX_W-1:0]  err_ctxid,
  output logic              busy
);

  localparam logic [2:0] OP_PUSH  = 3'b001;
  localparam logic [2:0] OP_POP   = 3'b010;
  localparam logic [2:0] OP_PEEK  = 3'b011;
  localparam logic [2:0] OP_FLUSH = 3'b100;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_RETIRE  = 2'b10;

  // Holding register (stage p0)
  logic              vld_p0;
  logic [2:0]        opcode_p0;
  logic [CTX_W-1:0]  ctxid_p0;
  logic [DATA_W-1:0] dat_p0;

  // In-flight scoreboard
  logic [SLOT_N-1:0] slot_vld;
  logic [CTX_W-1:0]  slot_ctx [SLOT_N];

  logic              legal;
  logic              ctx_hit;
  logic              free;
  logic [SLOT_W-1:0] alloc_slot;
  logic              hazard;
  logic              issue;
  logic              drop;
  logic              retire_ok;
  logic              retire_err;
  logic              accept;

  // Scoreboard lookup: same-context hit and lowest-index free slot
  always_comb begin
    ctx_hit    = 1'b0;
    free       = 1'b0;
    alloc_slot = '0;
    for (int i = 0; i < SLOT_N; i++) begin
      if (slot_vld[i] && (slot_ctx[i] == ctxid_p0)) ctx_hit = 1'b1;
      if (!slot_vld[i] && !free) begin
        free       = 1'b1;
        alloc_slot = SLOT_W'(i);
      end
    end
  end

  // Issue / drop / retire decisions; all use pre-edge scoreboard state so a
  // freed slot only becomes usable the cycle after its retire.
  always_comb begin
    legal      = (opcode_p0 == OP_PUSH) || (opcode_p0 == OP_POP) ||
                 (opcode_p0 == OP_PEEK) || (opcode_p0 == OP_FLUSH);
    hazard     = (opcode_p0 == OP_FLUSH) ? ((|slot_vld) | out_vld) : ctx_hit;
    issue      = vld_p0 & legal & ~hazard & free & (~out_vld | out_rdy);
    drop       = vld_p0 & ~legal;
    retire_ok  = retire_vld & slot_vld[retire_slot];
    retire_err = retire_vld & ~slot_vld[retire_slot];
    in_rdy     = ~rst & (~vld_p0 | issue | drop);
    accept     = in_vld & in_rdy;
    busy       = vld_p0 | out_vld | (|slot_vld);
  end

  // Holding register control: fill on accept, empty on issue or drop
  always_ff @(posedge clk) begin
    if (rst)                 vld_p0 <= 1'b0;
    else if (accept)         vld_p0 <= 1'b1;
    else if (issue || drop)  vld_p0 <= 1'b0;
  end

  // Holding register payload
  always_ff @(posedge clk) begin
    if (accept) begin
      opcode_p0 <= in_opcode;
      ctxid_p0  <= in_ctxid;
      dat_p0    <= in_dat;
    end
  end

  // Scoreboard valid bits: retire clears, issue sets the allocated slot
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld <= '0;
    end else begin
      if (retire_ok) slot_vld[retire_slot] <= 1'b0;
      if (issue)     slot_vld[alloc_slot]  <= 1'b1;
    end
  end

  // Scoreboard context tags
  always_ff @(posedge clk) begin
    if (issue) slot_ctx[alloc_slot] <= ctxid_p0;
  end

  // Output register (stage p1): held under backpressure, loaded on issue
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld    <= 1'b0;
      out_opcode <= '0;
      out_ctxid  <= '0;
      out_dat    <= '0;
      out_slot   <= '0;
    end else if (issue) begin
      out_vld    <= 1'b1;
      out_opcode <= opcode_p0;
      out_ctxid  <= ctxid_p0;
      out_dat    <= dat_p0;
      out_slot   <= alloc_slot;
    end else if (out_rdy) begin
      out_vld    <= 1'b0;
    end
  end

  // Error pulse; an illegal drop outranks a simultaneous bad retire
  always_ff @(posedge clk) begin
    if (rst) begin
      err_vld   <= 1'b0;
      err_code  <= ERR_NONE;
      err_ctxid <= '0;
    end else begin
      err_vld   <= drop | retire_err;
      err_code  <= drop ? ERR_ILLEGAL : (retire_err ? ERR_RETIRE : ERR_NONE);
      err_ctxid <= drop ? ctxid_p0 : '0;
    end
  end

endmodule

// File: tb/tb_eng_pipe_ad.sv
// Directed bench for eng_pipe_ad: issue flow, hazards, slot exhaustion,
// illegal opcodes, flush serialisation, backpressure and mid-stream reset.
module tb_eng_pipe_ad;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic [2:0]  in_opcode;
  logic [3:0]  in_ctxid;
  logic [31:0] in_dat;
  logic        in_rdy;
  logic        out_vld;
  logic [2:0]  out_opcode;
  logic [3:0]  out_ctxid;
  logic [31:0] out_dat;
  logic [1:0]  out_slot;
  logic        out_rdy;
  logic        retire_vld;
  logic [1:0]  retire_slot;
  logic        err_vld;
  logic [1:0]  err_code;
  logic [3:0]  err_ctxid;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  eng_pipe_ad #(.CTX_W(4), .DATA_W(32), .SLOT_N(4)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_opcode(in_opcode),
    .in_ctxid(in_ctxid), .in_dat(in_dat), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_opcode(out_opcode), .out_ctxid(out_ctxid),
    .out_dat(out_dat), .out_slot(out_slot), .out_rdy(out_rdy),
    .retire_vld(retire_vld), .retire_slot(retire_slot),
    .err_vld(err_vld), .err_code(err_code), .err_ctxid(err_ctxid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_vld = 1'b0; in_opcode = 3'b000; in_ctxid = 4'd0; in_dat = 32'd0;
    retire_vld = 1'b0; retire_slot = 2'd0; out_rdy = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic cmd(input logic [2:0] op, input logic [3:0] ctx, input logic [31:0] d);
    in_vld = 1'b1; in_opcode = op; in_ctxid = ctx; in_dat = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    nvec++; if (out_vld !== 1'b0) begin nerr++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
    nvec++; if (err_vld !== 1'b0) begin nerr++; $display("FAIL reset_err_vld got %b want 0", err_vld); end
    nvec++; if (in_rdy !== 1'b0) begin nerr++; $display("FAIL reset_in_rdy got %b want 0", in_rdy); end
    nvec++; if ({out_opcode, out_ctxid, out_dat, out_slot} !== 41'd0) begin nerr++; $display("FAIL reset_out_data got %h want 0", {out_opcode, out_ctxid, out_dat, out_slot}); end
    rst = 1'b0;
    #1;
    nvec++; if (in_rdy !== 1'b1) begin nerr++; $display("FAIL post_reset_in_rdy got %b want 1", in_rdy); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ctxs [3];
    ctxs[0] = 4'd1; ctxs[1] = 4'd2; ctxs[2] = 4'd3;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cmd(3'b001, ctxs[i], 32'hA000_0000 + 32'(i));
      #1;
      nvec++; if (in_rdy !== 1'b1) begin nerr++; $display("FAIL b2b_in_rdy[%0d] got %b want 1", i, in_rdy); end
      tick();
      if (i > 0) begin
        nvec++; if ({out_vld, out_ctxid, out_slot} !== {1'b1, ctxs[i-1], 2'(i-1)}) begin nerr++; $display("FAIL b2b_out[%0d] got vld=%b ctx=%0d slot=%0d want vld=1 ctx=%0d slot=%0d", i-1, out_vld, out_ctxid, out_slot, ctxs[i-1], i-1); end
      end
    end
    in_vld = 1'b0;
    tick();
    nvec++; if ({out_vld, out_opcode, out_ctxid, out_slot, out_dat} !== {1'b1, 3'b001, 4'd3, 2'd2, 32'hA000_0002}) begin nerr++; $display("FAIL b2b_out[2] got vld=%b op=%b ctx=%0d slot=%0d dat=%h want 1/001/3/2/a0000002", out_vld, out_opcode, out_ctxid, out_slot, out_dat); end
    tick();
    nvec++; if (out_vld !== 1'b0) begin nerr++; $display("FAIL b2b_drain got %b want 0", out_vld); end
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL b2b_busy_slots got %b want 1", busy); end
  endtask

  task automatic test_hazard();
    do_reset();
    cmd(3'b001, 4'd5, 32'h55);
    tick();
    cmd(3'b010, 4'd5, 32'h0);
    tick();
    in_vld = 1'b0;
    nvec++; if ({out_vld, out_slot} !== {1'b1, 2'd0}) begin nerr++; $display("FAIL haz_push got vld=%b slot=%0d want 1/0", out_vld, out_slot); end
    #1;
    nvec++; if (in_rdy !== 1'b0) begin nerr++; $display("FAIL haz_in_rdy got %b want 0", in_rdy); end
    for (int i = 0; i < 3; i++) tick();
    nvec++; if ({out_vld, in_rdy} !== 2'b00) begin nerr++; $display("FAIL haz_held got vld=%b rdy=%b want 0/0", out_vld, in_rdy); end
    retire_vld = 1'b1; retire_slot = 2'd0;
    tick();
    retire_vld = 1'b0;
    nvec++; if (out_vld !== 1'b0) begin nerr++; $display("FAIL haz_retire_edge got %b want 0", out_vld); end
    tick();
    nvec++; if ({out_vld, out_opcode, out_ctxid, out_slot} !== {1'b1, 3'b010, 4'd5, 2'd0}) begin nerr++; $display("FAIL haz_pop_issue got vld=%b op=%b ctx=%0d slot=%0d want 1/010/5/0", out_vld, out_opcode, out_ctxid, out_slot); end
  endtask

  task automatic test_full();
    logic [3:0] ctxs [5];
    ctxs[0] = 4'd1; ctxs[1] = 4'd2; ctxs[2] = 4'd3; ctxs[3] = 4'd4; ctxs[4] = 4'd6;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cmd(3'b001, ctxs[i], 32'(i));
      tick();
    end
    in_vld = 1'b0;
    nvec++; if ({out_vld, out_ctxid, out_slot} !== {1'b1, 4'd4, 2'd3}) begin nerr++; $display("FAIL full_4th got vld=%b ctx=%0d slot=%0d want 1/4/3", out_vld, out_ctxid, out_slot); end
    tick();
    nvec++; if ({out_vld, busy, in_rdy} !== 3'b010) begin nerr++; $display("FAIL full_stall got vld=%b busy=%b rdy=%b want 0/1/0", out_vld, busy, in_rdy); end
    retire_vld = 1'b1; retire_slot = 2'd2;
    tick();
    retire_vld = 1'b0;
    tick();
    nvec++; if ({out_vld, out_ctxid, out_slot} !== {1'b1, 4'd6, 2'd2}) begin nerr++; $display("FAIL full_5th got vld=%b ctx=%0d slot=%0d want 1/6/2", out_vld, out_ctxid, out_slot); end
  endtask

  task automatic test_illegal();
    do_reset();
    cmd(3'b111, 4'd9, 32'hDEAD);
    tick();
    in_vld = 1'b0;
    #1;
    nvec++; if (in_rdy !== 1'b1) begin nerr++; $display("FAIL ill_in_rdy got %b want 1", in_rdy); end
    tick();
    nvec++; if ({out_vld, err_vld, err_code, err_ctxid} !== {1'b0, 1'b1, 2'b01, 4'd9}) begin nerr++; $display("FAIL ill_err got vld=%b err=%b code=%b ctx=%0d want 0/1/01/9", out_vld, err_vld, err_code, err_ctxid); end
    tick();
    nvec++; if ({err_vld, busy} !== 2'b00) begin nerr++; $display("FAIL ill_pulse got err=%b busy=%b want 0/0", err_vld, busy); end
  endtask

  task automatic test_flush();
    do_reset();
    cmd(3'b001, 4'd1, 32'h1);
    tick();
    cmd(3'b001, 4'd2, 32'h2);
    tick();
    cmd(3'b100, 4'd0, 32'h0);
    tick();
    in_vld = 1'b0;
    nvec++; if ({out_vld, out_slot} !== {1'b1, 2'd1}) begin nerr++; $display("FAIL fl_push2 got vld=%b slot=%0d want 1/1", out_vld, out_slot); end
    tick();
    nvec++; if (out_vld !== 1'b0) begin nerr++; $display("FAIL fl_stall0 got %b want 0", out_vld); end
    retire_vld = 1'b1; retire_slot = 2'd0;
    tick();
    nvec++; if (out_vld !== 1'b0) begin nerr++; $display("FAIL fl_stall1 got %b want 0", out_vld); end
    retire_slot = 2'd1;
    tick();
    retire_vld = 1'b0;
    nvec++; if ({out_vld, err_vld} !== 2'b00) begin nerr++; $display("FAIL fl_stall2 got vld=%b err=%b want 0/0", out_vld, err_vld); end
    tick();
    nvec++; if ({out_vld, out_opcode, out_slot} !== {1'b1, 3'b100, 2'd0}) begin nerr++; $display("FAIL fl_issue got vld=%b op=%b slot=%0d want 1/100/0", out_vld, out_opcode, out_slot); end
    retire_vld = 1'b1; retire_slot = 2'd3;
    tick();
    retire_vld = 1'b0;
    nvec++; if ({err_vld, err_code, err_ctxid} !== {1'b1, 2'b10, 4'd0}) begin nerr++; $display("FAIL fl_bad_retire got err=%b code=%b ctx=%0d want 1/10/0", err_vld, err_code, err_ctxid); end
    tick();
    nvec++; if (err_vld !== 1'b0) begin nerr++; $display("FAIL fl_bad_retire_pulse got %b want 0", err_vld); end
  endtask

  task automatic test_err_priority();
    do_reset();
    cmd(3'b000, 4'd3, 32'h0);
    tick();
    in_vld = 1'b0;
    retire_vld = 1'b1; retire_slot = 2'd1;
    tick();
    retire_vld = 1'b0;
    nvec++; if ({err_vld, err_code, err_ctxid} !== {1'b1, 2'b01, 4'd3}) begin nerr++; $display("FAIL prio_err got err=%b code=%b ctx=%0d want 1/01/3", err_vld, err_code, err_ctxid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_rdy = 1'b0;
    cmd(3'b001, 4'd7, 32'h1234_5678);
    tick();
    cmd(3'b011, 4'd8, 32'h0BAD_F00D);
    tick();
    in_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nvec++; if ({out_vld, out_opcode, out_ctxid, out_dat, out_slot} !== {1'b1, 3'b001, 4'd7, 32'h1234_5678, 2'd0}) begin nerr++; $display("FAIL bp_stable[%0d] got vld=%b op=%b ctx=%0d dat=%h slot=%0d want 1/001/7/12345678/0", i, out_vld, out_opcode, out_ctxid, out_dat, out_slot); end
      tick();
    end
    out_rdy = 1'b1;
    tick();
    nvec++; if ({out_vld, out_opcode, out_ctxid, out_dat, out_slot} !== {1'b1, 3'b011, 4'd8, 32'h0BAD_F00D, 2'd1}) begin nerr++; $display("FAIL bp_release got vld=%b op=%b ctx=%0d dat=%h slot=%0d want 1/011/8/0badf00d/1", out_vld, out_opcode, out_ctxid, out_dat, out_slot); end
    cmd(3'b001, 4'd9, 32'h9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_vld = 1'b0;
    #1;
    nvec++; if ({out_vld, busy, err_vld} !== 3'b000) begin nerr++; $display("FAIL bp_mid_reset got vld=%b busy=%b err=%b want 0/0/0", out_vld, busy, err_vld); end
    tick();
    nvec++; if ({out_vld, busy, err_vld} !== 3'b000) begin nerr++; $display("FAIL bp_after_reset got vld=%b busy=%b err=%b want 0/0/0", out_vld, busy, err_vld); end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_back_to_back();
    test_hazard();
    test_full();
    test_illegal();
    test_flush();
    test_err_priority();
    test_backpressure();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
